// File: rtl/port_sram_binder.sv
// Binds write ports to free SRAM banks for one packet at a time and forwards
// the bound port's beats to its bank through a registered crossbar.
module port_sram_binder #(
  parameter int unsigned NUM_PORTS  = 16,
  parameter int unsigned NUM_SRAMS  = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PORT_IDX_W = $clog2(NUM_PORTS),
  parameter int unsigned SRAM_IDX_W = $clog2(NUM_SRAMS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRAMS-1:0]             bank_en,
  input  logic [NUM_PORTS-1:0]             alloc_req,
  input  logic [NUM_PORTS*NUM_SRAMS-1:0]   alloc_mask,
  input  logic [NUM_PORTS-1:0]             xfer_data_vld,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  xfer_data,
  input  logic [NUM_PORTS-1:0]             end_of_packet,
  output logic [NUM_PORTS-1:0]             alloc_gnt,
  output logic [NUM_PORTS-1:0]             bound,
  output logic [NUM_PORTS*SRAM_IDX_W-1:0]  alloc_sram,
  output logic [NUM_SRAMS-1:0]             sram_busy,
  output logic [NUM_SRAMS-1:0]             sram_vld,
  output logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_data,
  output logic [NUM_SRAMS-1:0]             sram_eop,
  output logic [NUM_SRAMS*PORT_IDX_W-1:0]  sram_src,
  output logic [NUM_PORTS-1:0]             err_unbound
);

  logic [NUM_PORTS-1:0]            alloc_gnt_q, alloc_gnt_d;
  logic [NUM_PORTS-1:0]            bound_q, bound_d;
  logic [NUM_PORTS*SRAM_IDX_W-1:0] alloc_sram_q, alloc_sram_d;
  logic [NUM_SRAMS-1:0]            sram_busy_q, sram_busy_d;
  logic [NUM_SRAMS-1:0]            sram_vld_q, sram_vld_d;
  logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_data_q, sram_data_d;
  logic [NUM_SRAMS-1:0]            sram_eop_q, sram_eop_d;
  logic [NUM_SRAMS*PORT_IDX_W-1:0] sram_src_q, sram_src_d;
  logic [NUM_PORTS-1:0]            err_unbound_q, err_unbound_d;
  logic [PORT_IDX_W-1:0]           rr_ptr_q, rr_ptr_d;

  logic                  win_found;
  logic [PORT_IDX_W-1:0] win_port;
  logic [SRAM_IDX_W-1:0] win_bank;

  // Round-robin search from rr_ptr; the winner takes its lowest free acceptable bank.
  always_comb begin : arb
    int unsigned          idx;
    logic [NUM_SRAMS-1:0] cand;
    win_found = 1'b0;
    win_port  = '0;
    win_bank  = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx  = (32'(rr_ptr_q) + i) % NUM_PORTS;
      cand = alloc_mask[idx*NUM_SRAMS +: NUM_SRAMS] & ~sram_busy_q & bank_en;
      if (!win_found && alloc_req[idx] && !bound_q[idx] && (|cand)) begin
        win_found = 1'b1;
        win_port  = PORT_IDX_W'(idx);
        for (int b = NUM_SRAMS - 1; b >= 0; b--) begin
          if (cand[b]) win_bank = SRAM_IDX_W'(b);
        end
      end
    end
  end

  // Beat forwarding, release on eop, unbound-beat flagging and grant bookkeeping.
  always_comb begin : nxt
    logic [SRAM_IDX_W-1:0] bank;
    alloc_gnt_d   = '0;
    bound_d       = bound_q;
    alloc_sram_d  = alloc_sram_q;
    sram_busy_d   = sram_busy_q;
    sram_vld_d    = '0;
    sram_data_d   = sram_data_q;
    sram_eop_d    = '0;
    sram_src_d    = sram_src_q;
    err_unbound_d = err_unbound_q;
    rr_ptr_d      = rr_ptr_q;
    bank          = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bank = alloc_sram_q[p*SRAM_IDX_W +: SRAM_IDX_W];
      if (xfer_data_vld[p]) begin
        if (bound_q[p]) begin
          sram_vld_d[bank] = 1'b1;
          sram_eop_d[bank] = end_of_packet[p];
          sram_data_d[bank*DATA_WIDTH +: DATA_WIDTH] = xfer_data[p*DATA_WIDTH +: DATA_WIDTH];
          if (end_of_packet[p]) begin
            bound_d[p]        = 1'b0;
            sram_busy_d[bank] = 1'b0;
          end
        end else begin
          err_unbound_d[p] = 1'b1;
        end
      end
    end
    // A releasing bank is still busy in this cycle, so it cannot collide with the winner.
    if (win_found) begin
      alloc_gnt_d[win_port] = 1'b1;
      bound_d[win_port]     = 1'b1;
      sram_busy_d[win_bank] = 1'b1;
      alloc_sram_d[win_port*SRAM_IDX_W +: SRAM_IDX_W] = win_bank;
      sram_src_d[win_bank*PORT_IDX_W +: PORT_IDX_W]   = win_port;
      rr_ptr_d = PORT_IDX_W'((32'(win_port) + 1) % NUM_PORTS);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_gnt_q   <= '0;
      bound_q       <= '0;
      alloc_sram_q  <= '0;
      sram_busy_q   <= '0;
      sram_vld_q    <= '0;
      sram_data_q   <= '0;
      sram_eop_q    <= '0;
      sram_src_q    <= '0;
      err_unbound_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      alloc_gnt_q   <= alloc_gnt_d;
      bound_q       <= bound_d;
      alloc_sram_q  <= alloc_sram_d;
      sram_busy_q   <= sram_busy_d;
      sram_vld_q    <= sram_vld_d;
      sram_data_q   <= sram_data_d;
      sram_eop_q    <= sram_eop_d;
      sram_src_q    <= sram_src_d;
      err_unbound_q <= err_unbound_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign alloc_gnt   = alloc_gnt_q;
  assign bound       = bound_q;
  assign alloc_sram  = alloc_sram_q;
  assign sram_busy   = sram_busy_q;
  assign sram_vld    = sram_vld_q;
  assign sram_data   = sram_data_q;
  assign sram_eop    = sram_eop_q;
  assign sram_src    = sram_src_q;
  assign err_unbound = err_unbound_q;

endmodule

// File: tb/tb_port_sram_binder.sv
// Scoreboard bench for port_sram_binder: stimulus pushes expected grants and
// forwarded beats, a negedge monitor pops and compares them as the DUT emits.
module tb_port_sram_binder;
  localparam int unsigned NP = 16;
  localparam int unsigned NS = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 4;
  localparam int unsigned SW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     bank_en;
  logic [NP-1:0]     alloc_req;
  logic [NP*NS-1:0]  alloc_mask;
  logic [NP-1:0]     xfer_data_vld;
  logic [NP*DW-1:0]  xfer_data;
  logic [NP-1:0]     end_of_packet;
  logic [NP-1:0]     alloc_gnt;
  logic [NP-1:0]     bound;
  logic [NP*SW-1:0]  alloc_sram;
  logic [NS-1:0]     sram_busy;
  logic [NS-1:0]     sram_vld;
  logic [NS*DW-1:0]  sram_data;
  logic [NS-1:0]     sram_eop;
  logic [NS*PW-1:0]  sram_src;
  logic [NP-1:0]     err_unbound;

  port_sram_binder dut (
    .clk(clk), .rst_n(rst_n), .bank_en(bank_en), .alloc_req(alloc_req),
    .alloc_mask(alloc_mask), .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
    .end_of_packet(end_of_packet), .alloc_gnt(alloc_gnt), .bound(bound),
    .alloc_sram(alloc_sram), .sram_busy(sram_busy), .sram_vld(sram_vld),
    .sram_data(sram_data), .sram_eop(sram_eop), .sram_src(sram_src),
    .err_unbound(err_unbound)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idx;
    int val;
    int eop;
    int src;
  } exp_t;

  exp_t gq[$];
  exp_t bq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every grant pulse and every forwarded beat must match the head of its queue.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int p = 0; p < int'(NP); p++) begin
      if (alloc_gnt[p]) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected port=%0d cycle=%0d expected=none", p, cyc);
        end else begin
          e = gq.pop_front();
          chk("gnt_port", p, e.idx);
          chk("gnt_cycle", cyc, e.cyc);
          chk("gnt_bank", alloc_sram[p*SW +: SW], e.val);
          chk("gnt_src", sram_src[e.val*PW +: PW], p);
          chk("gnt_busy", sram_busy[e.val], 1);
        end
      end
    end
    for (int b = 0; b < int'(NS); b++) begin
      if (sram_vld[b]) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected bank=%0d data=%0h expected=none", b, sram_data[b*DW +: DW]);
        end else begin
          e = bq.pop_front();
          chk("beat_bank", b, e.idx);
          chk("beat_cycle", cyc, e.cyc);
          chk("beat_data", sram_data[b*DW +: DW], e.val);
          chk("beat_eop", sram_eop[b], e.eop);
          chk("beat_src", sram_src[b*PW +: PW], e.src);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_gnt(input int dly, input int port, input int bank);
    exp_t e;
    e.cyc = cyc + dly; e.idx = port; e.val = bank; e.eop = 0; e.src = port;
    gq.push_back(e);
  endtask

  task automatic beat(input int p, input logic [DW-1:0] d, input bit eop, input int bank);
    exp_t e;
    e.cyc = cyc + 1; e.idx = bank; e.val = int'(d); e.eop = int'(eop); e.src = p;
    bq.push_back(e);
    xfer_data_vld[p]        = 1'b1;
    xfer_data[p*DW +: DW]   = d;
    end_of_packet[p]        = eop;
    step();
    xfer_data_vld[p]        = 1'b0;
    end_of_packet[p]        = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bank_en = '1; alloc_req = '0; alloc_mask = '0;
    xfer_data_vld = '0; xfer_data = '0; end_of_packet = '0;
    step(3);
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_bound", bound, 0);
    chk("rst_busy", sram_busy, 0);
    chk("rst_vld", sram_vld, 0);
    chk("rst_err", err_unbound, 0);
    rst_n = 1'b1;
    step();

    // Single port on mask 0xF0: bank 4, four beats, release on last.
    alloc_mask[3*NS +: NS] = 32'h0000_00F0;
    alloc_req[3] = 1'b1;
    expect_gnt(1, 3, 4);
    step();
    chk("t1_bound", bound, 16'h0008);
    chk("t1_busy", sram_busy, 32'h0000_0010);
    alloc_req[3] = 1'b0;
    for (int i = 0; i < 4; i++) beat(3, 16'hA000 + 16'(i), i == 3, 4);
    chk("t1_rel_bound", bound, 0);
    chk("t1_rel_busy", sram_busy, 0);

    // Round robin from rr_ptr=0: ports 0, 5, 15 on banks 0, 1, 2.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    alloc_mask[0*NS +: NS]  = '1;
    alloc_mask[5*NS +: NS]  = '1;
    alloc_mask[15*NS +: NS] = '1;
    alloc_req = 16'h8021;
    expect_gnt(1, 0, 0);
    expect_gnt(2, 5, 1);
    expect_gnt(3, 15, 2);
    step(3);
    alloc_req = '0;
    chk("t2_busy", sram_busy, 32'h0000_0007);
    beat(0, 16'hB000, 1'b1, 0);
    beat(5, 16'hB005, 1'b1, 1);
    beat(15, 16'hB00F, 1'b1, 2);
    chk("t2_rel_busy", sram_busy, 0);

    // Two ports contend for bank 7; port 2 follows two cycles after port 1's eop.
    alloc_mask[1*NS +: NS] = 32'h0000_0080;
    alloc_mask[2*NS +: NS] = 32'h0000_0080;
    alloc_req[1] = 1'b1; alloc_req[2] = 1'b1;
    expect_gnt(1, 1, 7);
    step();
    alloc_req[1] = 1'b0;
    beat(1, 16'hC000, 1'b0, 7);
    chk("t3_wait", bound, 16'h0002);
    expect_gnt(2, 2, 7);
    beat(1, 16'hC001, 1'b1, 7);
    step();
    chk("t3_bound2", bound, 16'h0004);
    alloc_req[2] = 1'b0;
    beat(2, 16'hC002, 1'b1, 7);

    // Disabled bank blocks allocation until re-enabled.
    bank_en = 32'hFFFF_FFFE;
    alloc_mask[0*NS +: NS] = 32'h0000_0001;
    alloc_req[0] = 1'b1;
    step(20);
    chk("t4_nobind", bound, 0);
    bank_en = '1;
    expect_gnt(1, 0, 0);
    step();
    alloc_req[0] = 1'b0;
    beat(0, 16'hD000, 1'b1, 0);

    // Beat from an unbound port is dropped and flagged sticky.
    xfer_data_vld[9] = 1'b1;
    xfer_data[9*DW +: DW] = 16'hEEEE;
    step();
    xfer_data_vld[9] = 1'b0;
    chk("t5_err", err_unbound, 16'h0200);
    step(3);
    chk("t5_err_hold", err_unbound, 16'h0200);
    chk("t5_data_hold", sram_data[0 +: DW], 16'hD000);

    // Reset mid-packet, then confirm arbitration restarts at port 0.
    alloc_mask[4*NS +: NS] = 32'h0000_0004;
    alloc_req[4] = 1'b1;
    expect_gnt(1, 4, 2);
    step();
    alloc_req[4] = 1'b0;
    beat(4, 16'hF000, 1'b0, 2);
    beat(4, 16'hF001, 1'b0, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_bound", bound, 0);
    chk("t6_busy", sram_busy, 0);
    chk("t6_eop", sram_eop, 0);
    chk("t6_err", err_unbound, 0);
    alloc_mask[6*NS +: NS] = '1;
    alloc_req[3] = 1'b1; alloc_req[6] = 1'b1;
    expect_gnt(1, 3, 4);
    expect_gnt(2, 6, 0);
    step(2);
    alloc_req = '0;
    beat(3, 16'h1111, 1'b1, 4);
    beat(6, 16'h2222, 1'b1, 0);
    step(3);
    chk("end_gq_empty", gq.size(), 0);
    chk("end_bq_empty", bq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
